// File: rtl/segre_ic_refill_pkg.sv
// ---------------------------------------------------------------------------
// segre_ic_refill_pkg
// Shared geometry constants and the refill FSM state type used by the
// instruction-cache refill engine and its LRU tracker.
// Optional feature macro (consumed by segre_ic_refill): SEGRE_IC_REFILL_WRAP_EN
// selects critical-word-first wrapping beat order.
// ---------------------------------------------------------------------------
package segre_ic_refill_pkg;

  localparam int ADDR_SIZE         = 32;
  localparam int WORD_SIZE         = 32;
  localparam int ICACHE_LINES      = 4;
  localparam int ICACHE_INDEX_SIZE = $clog2(ICACHE_LINES);
  localparam int ICACHE_LANE_SIZE  = 128;
  localparam int ICACHE_BYTE_SIZE  = ICACHE_LANE_SIZE / 8;

  localparam int ICACHE_BEATS      = ICACHE_LANE_SIZE / WORD_SIZE;
  localparam int BEAT_INDEX_SIZE   = (ICACHE_BEATS > 1) ? $clog2(ICACHE_BEATS) : 1;
  localparam int LANE_OFFSET_SIZE  = $clog2(ICACHE_BYTE_SIZE);
  localparam int WORD_OFFSET_SIZE  = $clog2(WORD_SIZE / 8);

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_FETCH,
    RF_DONE
  } ic_refill_state_e;

endpackage

// File: rtl/segre_ic_refill_icache_lru.sv
// ---------------------------------------------------------------------------
// segre_icache_lru
// Age-based LRU tracker for the instruction cache lines. Each line holds an
// age; the ages always form a permutation of 0..ICACHE_LINES-1 and the line
// with the largest age is the victim.
// Ports:
//   clk_i, rsn_i      clock, synchronous active-low reset
//   fill_i            refill completed for fill_index_i (wins over a hit)
//   fill_index_i      line just filled
//   hit_i             fetch-stage hit on hit_index_i
//   hit_index_i       line that hit
//   victim_o          current least-recently-used line
// ---------------------------------------------------------------------------
module segre_icache_lru
  import segre_ic_refill_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         fill_i,
  input  logic [ICACHE_INDEX_SIZE-1:0] fill_index_i,
  input  logic                         hit_i,
  input  logic [ICACHE_INDEX_SIZE-1:0] hit_index_i,
  output logic [ICACHE_INDEX_SIZE-1:0] victim_o
);

  logic [ICACHE_INDEX_SIZE-1:0] age_q [ICACHE_LINES];
  logic [ICACHE_INDEX_SIZE-1:0] age_d [ICACHE_LINES];
  logic                         accessEn;
  logic [ICACHE_INDEX_SIZE-1:0] accessIdx;
  logic [ICACHE_INDEX_SIZE-1:0] maxAge;

  // A fill and a hit can land in the same cycle; the fill owns the access
  // port then and the hit is simply dropped. The accessed line becomes the
  // youngest and every line that was younger than it ages by one, which keeps
  // the ages a permutation.
  always_comb begin
    accessEn  = fill_i | hit_i;
    accessIdx = fill_i ? fill_index_i : hit_index_i;
    age_d     = age_q;
    if (accessEn) begin
      for (int i = 0; i < ICACHE_LINES; i++) begin
        if (ICACHE_INDEX_SIZE'(i) == accessIdx) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[accessIdx]) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  // Reset seeds the ages in descending order so that line 0 is the oldest
  // and consecutive fills after reset walk through lines 0,1,2,...
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      for (int i = 0; i < ICACHE_LINES; i++) begin
        age_q[i] <= ICACHE_INDEX_SIZE'(ICACHE_LINES - 1 - i);
      end
    end else begin
      age_q <= age_d;
    end
  end

  // Victim is the oldest line; the strict compare keeps the lowest index on
  // a tie, although legal ages never tie.
  always_comb begin
    victim_o = '0;
    maxAge   = age_q[0];
    for (int i = 1; i < ICACHE_LINES; i++) begin
      if (age_q[i] > maxAge) begin
        maxAge   = age_q[i];
        victim_o = ICACHE_INDEX_SIZE'(i);
      end
    end
  end

endmodule

// File: rtl/segre_ic_refill.sv
// ---------------------------------------------------------------------------
// segre_ic_refill
// Instruction-cache refill engine sitting in front of the fetch stage. On a
// fetch miss it picks the LRU victim line, reads the whole lane from memory
// one word per beat and hands it to the cache as a one-cycle fill pulse.
// Fetch-stage hits also refresh LRU recency while the engine is idle.
// Ports:
//   clk_i, rsn_i       clock, synchronous active-low reset
//   ic_access_i        fetch stage did a tag lookup this cycle
//   ic_miss_i          that lookup missed
//   ic_addr_i          miss: full PC; hit: zero-extended line index
//   mmu_data_o         one-cycle fill pulse
//   mmu_wr_data_o      assembled lane, word i holds address base+4i
//   mmu_lru_index_o    victim line for the fill
//   mem_rd_o           memory read request
//   mem_addr_o         word-aligned beat address
//   mem_ready_i        mem_data_i is valid this cycle
//   mem_data_i         beat data
//   busy_o             refill in progress
// Optional feature: define SEGRE_IC_REFILL_WRAP_EN for critical-word-first
// wrapping beat order; otherwise beats go linearly from the lane base.
// ---------------------------------------------------------------------------
module segre_ic_refill
  import segre_ic_refill_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         ic_access_i,
  input  logic                         ic_miss_i,
  input  logic [ADDR_SIZE-1:0]         ic_addr_i,
  output logic                         mmu_data_o,
  output logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data_o,
  output logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index_o,
  output logic                         mem_rd_o,
  output logic [ADDR_SIZE-1:0]         mem_addr_o,
  input  logic                         mem_ready_i,
  input  logic [WORD_SIZE-1:0]         mem_data_i,
  output logic                         busy_o
);

  ic_refill_state_e             state_q, state_d;
  logic [BEAT_INDEX_SIZE-1:0]   cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0]         base_q, base_d;
  logic [ICACHE_INDEX_SIZE-1:0] victim_q, victim_d;
  logic [ICACHE_LANE_SIZE-1:0]  lane_q, lane_d;
  logic [BEAT_INDEX_SIZE-1:0]   beatSlot;
  logic [ICACHE_INDEX_SIZE-1:0] lruVictim;
  logic                         missTake;
  logic                         hitTake;
  logic                         fillTake;

`ifdef SEGRE_IC_REFILL_WRAP_EN
  logic [BEAT_INDEX_SIZE-1:0]   missWord_q, missWord_d;

  // Wrapping order starts at the word that missed so the fetch stage's
  // critical word arrives first; slot placement is still by address.
  always_comb begin
    beatSlot = missWord_q + cnt_q;
  end
`else
  logic                         unusedWordOffset;

  // Linear order walks the lane from its base address.
  always_comb begin
    beatSlot = cnt_q;
  end

  assign unusedWordOffset = ^ic_addr_i[LANE_OFFSET_SIZE-1:WORD_OFFSET_SIZE];
`endif

  assign missTake = (state_q == RF_IDLE) && ic_access_i && ic_miss_i;
  assign hitTake  = (state_q == RF_IDLE) && ic_access_i && !ic_miss_i;
  assign fillTake = (state_q == RF_DONE);

  segre_icache_lru u_lru (
    .clk_i        (clk_i),
    .rsn_i        (rsn_i),
    .fill_i       (fillTake),
    .fill_index_i (victim_q),
    .hit_i        (hitTake),
    .hit_index_i  (ic_addr_i[ICACHE_INDEX_SIZE-1:0]),
    .victim_o     (lruVictim)
  );

  // Next-state logic for the refill FSM. A miss is only accepted while idle,
  // which also covers the first idle cycle right after a fill. In FETCH the
  // beat address is held until memory answers, and each answered beat is
  // dropped into the lane slot that matches its address.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    victim_d = victim_q;
    lane_d   = lane_q;
`ifdef SEGRE_IC_REFILL_WRAP_EN
    missWord_d = missWord_q;
`endif
    case (state_q)
      RF_IDLE: begin
        if (missTake) begin
          base_d   = {ic_addr_i[ADDR_SIZE-1:LANE_OFFSET_SIZE], {LANE_OFFSET_SIZE{1'b0}}};
          victim_d = lruVictim;
          cnt_d    = '0;
`ifdef SEGRE_IC_REFILL_WRAP_EN
          missWord_d = ic_addr_i[LANE_OFFSET_SIZE-1:WORD_OFFSET_SIZE];
`endif
          state_d  = RF_FETCH;
        end
      end
      RF_FETCH: begin
        if (mem_ready_i) begin
          lane_d[beatSlot*WORD_SIZE +: WORD_SIZE] = mem_data_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BEAT_INDEX_SIZE'(ICACHE_BEATS - 1)) begin
            state_d = RF_DONE;
          end
        end
      end
      RF_DONE: begin
        state_d = RF_IDLE;
      end
      default: begin
        state_d = RF_IDLE;
      end
    endcase
  end

  // State register. Reset wins even in the middle of a refill: the lane and
  // beat counter are wiped so a half-fetched line can never leak out.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q  <= RF_IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      victim_q <= '0;
      lane_q   <= '0;
`ifdef SEGRE_IC_REFILL_WRAP_EN
      missWord_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      victim_q <= victim_d;
      lane_q   <= lane_d;
`ifdef SEGRE_IC_REFILL_WRAP_EN
      missWord_q <= missWord_d;
`endif
    end
  end

  // Outputs are decoded from registered state only. The lane and victim stay
  // visible after the fill pulse until the next refill starts writing.
  always_comb begin
    mem_rd_o        = (state_q == RF_FETCH);
    mem_addr_o      = '0;
    if (state_q == RF_FETCH) begin
      mem_addr_o = base_q + (ADDR_SIZE'(beatSlot) << WORD_OFFSET_SIZE);
    end
    mmu_data_o      = (state_q == RF_DONE);
    mmu_wr_data_o   = lane_q;
    mmu_lru_index_o = victim_q;
    busy_o          = (state_q != RF_IDLE);
  end

endmodule

// File: tb/tb_segre_ic_refill.sv
// ---------------------------------------------------------------------------
// tb_segre_ic_refill
// Self-checking bench for segre_ic_refill. Directed table of refills and hits,
// a mid-refill reset sequence, then randomized traffic compared against a
// recency-list model of LRU and an address-indexed memory model.
// ---------------------------------------------------------------------------
module tb_segre_ic_refill;
  import segre_ic_refill_pkg::*;

  logic                         clk = 1'b0;
  logic                         rsn_i;
  logic                         ic_access_i;
  logic                         ic_miss_i;
  logic [ADDR_SIZE-1:0]         ic_addr_i;
  logic                         mmu_data_o;
  logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data_o;
  logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index_o;
  logic                         mem_rd_o;
  logic [ADDR_SIZE-1:0]         mem_addr_o;
  logic                         mem_ready_i;
  logic [WORD_SIZE-1:0]         mem_data_i;
  logic                         busy_o;

  int checks = 0;
  int errors = 0;
  int recency[$];
  logic [31:0] words [4];

  typedef struct {
    logic [31:0] addr;
    int stallBeat;
    int stallCycles;
    int during;
    int doneHit;
    int hitBefore;
    int expVictim;
  } vec_t;

  vec_t vecs [7];

  segre_ic_refill dut (
    .clk_i           (clk),
    .rsn_i           (rsn_i),
    .ic_access_i     (ic_access_i),
    .ic_miss_i       (ic_miss_i),
    .ic_addr_i       (ic_addr_i),
    .mmu_data_o      (mmu_data_o),
    .mmu_wr_data_o   (mmu_wr_data_o),
    .mmu_lru_index_o (mmu_lru_index_o),
    .mem_rd_o        (mem_rd_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ready_i     (mem_ready_i),
    .mem_data_i      (mem_data_i),
    .busy_o          (busy_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Comparison helper shared by every check in the bench.
  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Recency list, most recent first; the victim is the last entry.
  task automatic modelReset();
    recency = {};
    for (int i = ICACHE_LINES - 1; i >= 0; i--) recency.push_back(i);
  endtask

  task automatic modelAccess(input int k);
    for (int i = 0; i < recency.size(); i++) begin
      if (recency[i] == k) begin
        recency.delete(i);
        break;
      end
    end
    recency.push_front(k);
  endtask

  function automatic int modelVictim();
    return recency[recency.size() - 1];
  endfunction

  // Hold reset for two cycles and confirm every output is cleared.
  task automatic applyReset();
    rsn_i       = 1'b0;
    ic_access_i = 1'b0;
    ic_miss_i   = 1'b0;
    ic_addr_i   = '0;
    mem_ready_i = 1'b0;
    mem_data_i  = '0;
    stepCycle();
    stepCycle();
    checkOutput("rst_mmu_data", mmu_data_o, 0);
    checkOutput("rst_wr_data", mmu_wr_data_o, 0);
    checkOutput("rst_index", mmu_lru_index_o, 0);
    checkOutput("rst_mem_rd", mem_rd_o, 0);
    checkOutput("rst_mem_addr", mem_addr_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    rsn_i = 1'b1;
    modelReset();
  endtask

  // Fetch-stage hit on a line while the engine is idle.
  task automatic applyHit(input int idx);
    ic_access_i = 1'b1;
    ic_miss_i   = 1'b0;
    ic_addr_i   = 32'(idx);
    stepCycle();
    ic_access_i = 1'b0;
    ic_addr_i   = '0;
    modelAccess(idx);
    checkOutput("hit_idle", busy_o, 0);
  endtask

  // One full refill, checked cycle by cycle.
  // during: 0 quiet, 1 another miss held through FETCH, 2 a hit held through FETCH.
  // doneHit: line index hit in the DONE cycle (ignored by design), or -1.
  task automatic applyStimulus(input logic [31:0] addr, input int stallBeat, input int stallCycles,
                               input int during, input int doneHit, input int expVictim);
    logic [31:0]  base;
    logic [127:0] expLane;
    logic [31:0]  a;
    int           first;
    int           slot;
    int           stalls;
    base = {addr[31:4], 4'h0};
`ifdef SEGRE_IC_REFILL_WRAP_EN
    first = int'(addr[3:2]);
`else
    first = 0;
`endif
    for (int s = 0; s < 4; s++) begin
      words[s] = $urandom;
      expLane[s*32 +: 32] = words[s];
    end
    checkOutput("idle_before", busy_o, 0);
    ic_access_i = 1'b1;
    ic_miss_i   = 1'b1;
    ic_addr_i   = addr;
    stepCycle();
    case (during)
      1: begin ic_access_i = 1'b1; ic_miss_i = 1'b1; ic_addr_i = addr ^ 32'h0010_0040; end
      2: begin ic_access_i = 1'b1; ic_miss_i = 1'b0; ic_addr_i = 32'((expVictim + 2) % 4); end
      default: begin ic_access_i = 1'b0; ic_miss_i = 1'b0; ic_addr_i = '0; end
    endcase
    for (int b = 0; b < 4; b++) begin
      slot   = (first + b) % 4;
      a      = base + 32'(4 * slot);
      stalls = (b == stallBeat) ? stallCycles : 0;
      for (int st = 0; st < stalls; st++) begin
        mem_ready_i = 1'b0;
        checkOutput("stall_rd", mem_rd_o, 1);
        checkOutput("stall_addr", mem_addr_o, a);
        checkOutput("stall_no_pulse", mmu_data_o, 0);
        stepCycle();
      end
      mem_ready_i = 1'b1;
      mem_data_i  = words[slot];
      checkOutput("beat_rd", mem_rd_o, 1);
      checkOutput("beat_addr", mem_addr_o, a);
      checkOutput("beat_no_pulse", mmu_data_o, 0);
      stepCycle();
    end
    mem_ready_i = 1'b0;
    mem_data_i  = '0;
    if (doneHit >= 0) begin
      ic_access_i = 1'b1; ic_miss_i = 1'b0; ic_addr_i = 32'(doneHit);
    end else begin
      ic_access_i = 1'b0; ic_miss_i = 1'b0; ic_addr_i = '0;
    end
    checkOutput("done_pulse", mmu_data_o, 1);
    checkOutput("done_mem_rd", mem_rd_o, 0);
    checkOutput("done_lane", mmu_wr_data_o, expLane);
    checkOutput("done_victim", mmu_lru_index_o, 128'(expVictim));
    checkOutput("done_busy", busy_o, 1);
    modelAccess(expVictim);
    stepCycle();
    ic_access_i = 1'b0;
    ic_miss_i   = 1'b0;
    ic_addr_i   = '0;
    checkOutput("after_pulse", mmu_data_o, 0);
    checkOutput("after_busy", busy_o, 0);
    checkOutput("hold_lane", mmu_wr_data_o, expLane);
    checkOutput("hold_victim", mmu_lru_index_o, 128'(expVictim));
  endtask

  // Reset asserted while beat 2 of a refill is on the bus.
  task automatic midRefillReset(input logic [31:0] addr);
    ic_access_i = 1'b1;
    ic_miss_i   = 1'b1;
    ic_addr_i   = addr;
    stepCycle();
    ic_access_i = 1'b0;
    ic_miss_i   = 1'b0;
    mem_ready_i = 1'b1;
    for (int b = 0; b < 2; b++) begin
      mem_data_i = $urandom;
      stepCycle();
    end
    checkOutput("mid_beat2_rd", mem_rd_o, 1);
    rsn_i      = 1'b0;
    mem_data_i = $urandom;
    stepCycle();
    checkOutput("mid_rst_busy", busy_o, 0);
    checkOutput("mid_rst_mem_rd", mem_rd_o, 0);
    checkOutput("mid_rst_pulse", mmu_data_o, 0);
    checkOutput("mid_rst_lane", mmu_wr_data_o, 0);
    checkOutput("mid_rst_index", mmu_lru_index_o, 0);
    rsn_i       = 1'b1;
    mem_ready_i = 1'b0;
    mem_data_i  = '0;
    modelReset();
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput("mid_rst_no_pulse", mmu_data_o, 0);
      checkOutput("mid_rst_idle", busy_o, 0);
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_1048, 4, 0, 0, -1, -1, 0};
    vecs[1] = '{32'h0000_1048, 2, 3, 0, -1, -1, 1};
    vecs[2] = '{32'h0000_3014, 4, 0, 1, -1, -1, 2};
    vecs[3] = '{32'h0000_400C, 1, 1, 2, -1, -1, 3};
    vecs[4] = '{32'h0000_5004, 4, 0, 0,  2,  0, 1};
    vecs[5] = '{32'h0000_6000, 0, 2, 0, -1, -1, 2};
    vecs[6] = '{32'h0000_7FFC, 3, 1, 0, -1,  3, 0};

    @(negedge clk);
    applyReset();
    stepCycle();

    $display("[TB] directed refill table");
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].hitBefore >= 0) applyHit(vecs[v].hitBefore);
      applyStimulus(vecs[v].addr, vecs[v].stallBeat, vecs[v].stallCycles,
                    vecs[v].during, vecs[v].doneHit, vecs[v].expVictim);
    end

    $display("[TB] reset during refill");
    midRefillReset(32'h0000_1048);
    applyStimulus(32'h0000_1048, 4, 0, 0, -1, 0);

    $display("[TB] randomized traffic");
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        applyHit(int'($urandom_range(0, 3)));
      end else begin
        applyStimulus($urandom, int'($urandom_range(0, 4)), int'($urandom_range(1, 3)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 4)) - 1, modelVictim());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
